// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response bundle between the datapath and the memory responder
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] mar_addr;
    logic [DATA_WIDTH-1:0] mdr_data;
    logic                  Read;
    logic                  Write;
    logic [DATA_WIDTH-1:0] Mdatain;
    logic                  mem_ready;
    logic                  mem_busy;

    modport master (
        output mar_addr, mdr_data, Read, Write,
        input  Mdatain, mem_ready, mem_busy
    );

    modport slave (
        input  mar_addr, mdr_data, Read, Write,
        output Mdatain, mem_ready, mem_busy
    );
endinterface

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed RAM serving datapath reads/writes after fixed wait states
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clock,
    input  logic            clear,
    mem_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  req_q;
    logic                  start;
    logic                  accept;
    logic                  access;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  op_write_q;
    logic [DATA_WIDTH-1:0] mdatain_q;
    logic                  ready_q;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // A request is a rising edge of the combined request level; a held level never retriggers.
    assign start = (bus.Read | bus.Write) & ~req_q;

    // Next-state logic: accept only from IDLE, count wait states, access when the count runs out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    cnt_d   = WAIT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, wait counter and request-edge history; reset abandons any in-flight request.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= bus.Read | bus.Write;
        end
    end

    // Capture address, data and operation at the accept edge; write wins when both are raised.
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_q     <= bus.mar_addr;
            data_q     <= bus.mdr_data;
            op_write_q <= bus.Write;
        end
    end

    // Registered response: completion pulse on the access edge, read data held until the next read.
    always_ff @(posedge clock) begin
        if (!clear) begin
            mdatain_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            ready_q <= access;
            if (access && !op_write_q) begin
                mdatain_q <= mem[addr_q];
            end
        end
    end

    // RAM write port; contents survive reset, and a reset edge suppresses a pending write.
    always_ff @(posedge clock) begin
        if (clear && access && op_write_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.Mdatain   = mdatain_q;
    assign bus.mem_ready = ready_q;
    assign bus.mem_busy  = (state_q != IDLE);
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the datapath's Read/Write interface. It samples the MAR address and MDR write data and services each request after a fixed number of wait states. Read data is returned on the datapath's `Mdatain` bus, and a one-cycle `mem_ready` pulse marks completion so the control sequencer can advance past its memory step. It holds the word-addressed RAM that the datapath loads from and stores to.

## Interface
- `ADDR_WIDTH`, 9: address bits; the RAM has 2^ADDR_WIDTH words.
- `DATA_WIDTH`, 32: word width.
- `WAIT_CYCLES`, 2: wait states between accept and access, range 0..15.

- `clock`  in  1: single clock; all state changes on the rising edge.
- `clear`  in  1: reset, synchronous, active-low; `clear`=0 at a rising edge resets.
- `mar_addr`  in  ADDR_WIDTH: word address from MAR.
- `mdr_data`  in  DATA_WIDTH: write data from MDR.
- `Read`  in  1: read request (level).
- `Write`  in  1: write request (level).
- `Mdatain`  out  DATA_WIDTH: read data to the MDR input mux; registered.
- `mem_ready`  out  1: one-cycle completion pulse; registered.
- `mem_busy`  out  1: high while a request is in flight (WAIT or DONE).

## Operation
- Request detection:
  - Registered previous value `req_q` = `Read | Write`.
  - A request *starts* on a sampled 0→1 transition of `Read | Write`.
  - A level held high for many cycles is one request; it never retriggers.
- Priority: if `Read` and `Write` are both high at the start edge, the request is a write. The read is not serviced.
- FSM states: IDLE, WAIT, DONE.
  - IDLE, start detected:
    - Latch `mar_addr`, `mdr_data`, and op (write if `Write` else read).
    - Set cnt <= `WAIT_CYCLES`; go to WAIT.
  - IDLE, no start: stay in IDLE.
  - WAIT, cnt≠0: cnt <= cnt−1.
  - WAIT, cnt=0:
    - Perform the access: write mem[addr] <= data, or read `Mdatain` <= mem[addr].
    - Set `mem_ready` <= 1; go to DONE.
  - DONE: `mem_ready` <= 0; go to IDLE.
- Starts detected in WAIT or DONE are dropped, not queued. `req_q` still updates every cycle.
- `mem_busy` = (state≠IDLE), combinational from the state register.
- `Mdatain` changes only on read completion. It holds the last read value through writes and idle time.
- Addresses wrap naturally: all ADDR_WIDTH bits are used, and there is no out-of-range case.
- Reset (`clear`=0 at an edge), from any state including mid-WAIT:
  - State <= IDLE, cnt <= 0, `req_q` <= 0.
  - `Mdatain` <= 0, `mem_ready` <= 0.
  - A pending access is abandoned; no memory write occurs.
  - RAM contents are not reset.
- After reset, `req_q`=0. A request line already high when `clear` returns to 1 therefore counts as a start on the first edge.

## Timing
- Accept at edge k.
- Access and `mem_ready` rise at edge k+`WAIT_CYCLES`+1.
- `mem_ready` falls at edge k+`WAIT_CYCLES`+2; IDLE from the same edge.
- `Mdatain` is valid from edge k+`WAIT_CYCLES`+1 until the next read completes.
- `WAIT_CYCLES`=0: access at edge k+1.
- `mem_busy` is high from after edge k until after edge k+`WAIT_CYCLES`+2.
- Minimum start-to-start spacing is `WAIT_CYCLES`+3 edges.
- The requester must drop `Read`/`Write` for at least one sampled edge between requests.
- The requester may hold the request through `mem_ready`.
- Address and data are captured at the accept edge. Changes to `mar_addr` or `mdr_data` afterwards do not affect the in-flight access.

## Test plan
- Write then read, `WAIT_CYCLES`=2:
  - Write 0xDEADBEEF to address 5 → `mem_ready` at accept+3.
  - Read address 5 → `Mdatain`=0xDEADBEEF at accept+3, `mem_ready` high exactly one cycle.
- Held read:
  - `Read` high for 10 cycles at address 7 → exactly one `mem_ready` pulse.
  - `mem_busy` low after accept+4; no second access.
- Simultaneous `Read`+`Write` rise at address 3 with data 0x12345678:
  - Write is performed; `Mdatain` unchanged (prior value 0).
  - A later read of address 3 returns 0x12345678.
- Reset mid-operation:
  - Start a write of 0xAAAA5555 to address 9, then pull `clear` low at accept+1.
  - Outputs go to 0 and the FSM to IDLE.
  - A later read of address 9 returns the pre-existing value, not 0xAAAA5555.
- Dropped request and wrap:
  - Pulse `Read` low then high while busy → no extra `mem_ready`.
  - Write 0x1 to address 511, then read 511 → 0x1.
  - Read 0 → address 0's value, independent of address 511.
- `WAIT_CYCLES`=0 instance: read completes with `mem_ready` at accept+1, `mem_busy` low after accept+2.
